// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back data mux, and a small
// FIFO that slots long-latency results into idle write-back cycles.
module wb_stage #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mem_valid_i,
    input  logic                          mem_reg_write_i,
    input  logic [4:0]                    mem_rd_addr_i,
    input  logic [1:0]                    mem_to_reg_i,
    input  logic [31:0]                   mem_alu_result_i,
    input  logic [31:0]                   mem_rdata_i,
    input  logic [31:0]                   mem_pc_plus_4_i,
    input  logic                          div_valid_i,
    input  logic [4:0]                    div_rd_addr_i,
    input  logic [31:0]                   div_result_i,
    output logic                          div_ready_o,
    output logic                          wb_reg_write_o,
    output logic [4:0]                    wb_rd_addr_o,
    output logic [31:0]                   wb_data_o,
    output logic                          stall_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

    logic             r_vld_p1;
    logic             r_we_p1;
    logic [4:0]       r_rd_p1;
    logic [31:0]      r_data_p1;

    logic [4:0]       r_fifo_rd   [FIFO_DEPTH];
    logic [31:0]      r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [SC_W-1:0]  r_starve;

    logic             w_pipe_wr;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_ready;
    logic             w_stall;
    logic [4:0]       w_head_rd;
    logic [31:0]      w_head_data;

    function automatic logic [31:0] sel_wb_data(input logic [1:0]  sel,
                                                input logic [31:0] alu,
                                                input logic [31:0] rdata,
                                                input logic [31:0] pc4);
        case (sel)
            2'b01:   return rdata;
            2'b10:   return pc4;
            default: return alu;
        endcase
    endfunction

    assign w_pipe_wr   = r_vld_p1 && r_we_p1 && (r_rd_p1 != 5'd0);
    assign w_empty     = (r_count == '0);
    assign w_pop       = !w_pipe_wr && !w_empty;
    assign w_ready     = (r_count < DEPTH_C);
    assign w_push      = div_valid_i && w_ready;
    assign w_stall     = (r_starve == LIMIT_C);
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // MEM -> WB boundary: a stall inserts a bubble while upstream holds its inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_we_p1   <= 1'b0;
            r_rd_p1   <= 5'd0;
            r_data_p1 <= 32'd0;
        end else if (w_stall) begin
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1  <= mem_valid_i;
            r_we_p1   <= mem_reg_write_i;
            r_rd_p1   <= mem_rd_addr_i;
            r_data_p1 <= sel_wb_data(mem_to_reg_i, mem_alu_result_i,
                                     mem_rdata_i, mem_pc_plus_4_i);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= div_rd_addr_i;
            r_fifo_data[r_wptr] <= div_result_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A stall cycle also clears the wait count: the bubble it inserts forces a pop next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_pop || w_empty || w_stall) begin
            r_starve <= '0;
        end else if (r_starve != LIMIT_C) begin
            r_starve <= r_starve + SC_W'(1);
        end
    end

    always_comb begin
        wb_reg_write_o = 1'b0;
        wb_rd_addr_o   = 5'd0;
        wb_data_o      = 32'd0;
        if (w_pipe_wr) begin
            wb_reg_write_o = 1'b1;
            wb_rd_addr_o   = r_rd_p1;
            wb_data_o      = r_data_p1;
        end else if (!w_empty) begin
            wb_reg_write_o = (w_head_rd != 5'd0);
            wb_rd_addr_o   = w_head_rd;
            wb_data_o      = w_head_data;
        end
    end

    assign div_ready_o  = w_ready;
    assign stall_o      = w_stall;
    assign fifo_count_o = r_count;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand-written starvation sequence,
// randomized traffic against a queue-based reference model, and reset checks.
module tb_wb_stage;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i, mem_reg_write_i;
    logic [4:0]  mem_rd_addr_i;
    logic [1:0]  mem_to_reg_i;
    logic [31:0] mem_alu_result_i, mem_rdata_i, mem_pc_plus_4_i;
    logic        div_valid_i;
    logic [4:0]  div_rd_addr_i;
    logic [31:0] div_result_i;
    logic        div_ready_o, wb_reg_write_o, stall_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o;
    logic [1:0]  fifo_count_o;

    wb_stage #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid_i(mem_valid_i), .mem_reg_write_i(mem_reg_write_i),
        .mem_rd_addr_i(mem_rd_addr_i), .mem_to_reg_i(mem_to_reg_i),
        .mem_alu_result_i(mem_alu_result_i), .mem_rdata_i(mem_rdata_i),
        .mem_pc_plus_4_i(mem_pc_plus_4_i),
        .div_valid_i(div_valid_i), .div_rd_addr_i(div_rd_addr_i),
        .div_result_i(div_result_i), .div_ready_o(div_ready_o),
        .wb_reg_write_o(wb_reg_write_o), .wb_rd_addr_o(wb_rd_addr_o),
        .wb_data_o(wb_data_o), .stall_o(stall_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic exp6(input string tag, input logic wr, input logic [4:0] rd,
                        input logic [31:0] d, input int cnt, input logic rdy, input logic stl);
        chk({tag, "_wr"},    32'(wb_reg_write_o), 32'(wr));
        chk({tag, "_rd"},    32'(wb_rd_addr_o),   32'(rd));
        chk({tag, "_data"},  wb_data_o,           d);
        chk({tag, "_cnt"},   32'(fifo_count_o),   32'(cnt));
        chk({tag, "_ready"}, 32'(div_ready_o),    32'(rdy));
        chk({tag, "_stall"}, 32'(stall_o),        32'(stl));
    endtask

    task automatic set_mem(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] mt,
                           input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4);
        mem_valid_i = v; mem_reg_write_i = w; mem_rd_addr_i = rd; mem_to_reg_i = mt;
        mem_alu_result_i = alu; mem_rdata_i = rdata; mem_pc_plus_4_i = pc4;
    endtask

    task automatic set_div(input logic v, input logic [4:0] rd, input logic [31:0] d);
        div_valid_i = v; div_rd_addr_i = rd; div_result_i = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        mv, rw;
        logic [4:0]  rd;
        logic [1:0]  mt;
        logic [31:0] alu, rdata, pc4;
        logic        dv;
        logic [4:0]  drd;
        logic [31:0] dd;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        int          e_cnt;
    } vec_t;

    vec_t tbl[8];

    // Reference model: registered MEM/WB record, a queue of buffered results,
    // and the number of cycles the current FIFO head has waited.
    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    logic        m_vld, m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_wait;

    task automatic model_reset();
        mq.delete();
        m_vld = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_wait = 0;
    endtask

    task automatic model_check();
        logic        pw, dchk;
        logic [31:0] e_wr, e_rd, e_d;
        pw = m_vld && m_we && (m_rd != 5'd0);
        dchk = 1'b1;
        if (pw) begin
            e_wr = 1; e_rd = 32'(m_rd); e_d = m_data;
        end else if (mq.size() > 0) begin
            e_wr = 32'(mq[0].rd != 5'd0); e_rd = 32'(mq[0].rd); e_d = mq[0].d;
            dchk = (mq[0].rd != 5'd0);
        end else begin
            e_wr = 0; e_rd = 0; e_d = 0;
        end
        chk("rnd_wr", 32'(wb_reg_write_o), e_wr);
        chk("rnd_rd", 32'(wb_rd_addr_o), e_rd);
        if (dchk) chk("rnd_data", wb_data_o, e_d);
        chk("rnd_cnt", 32'(fifo_count_o), 32'(mq.size()));
        chk("rnd_ready", 32'(div_ready_o), 32'(mq.size() < DEPTH));
        chk("rnd_stall", 32'(stall_o), 32'(m_wait == LIMIT));
    endtask

    task automatic model_advance();
        logic pw, pop, push, stl, was_empty;
        ent_t e;
        pw = m_vld && m_we && (m_rd != 5'd0);
        was_empty = (mq.size() == 0);
        pop = !pw && !was_empty;
        push = div_valid_i && (mq.size() < DEPTH);
        stl = (m_wait == LIMIT);
        e.rd = div_rd_addr_i; e.d = div_result_i;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        if (was_empty || pop || stl) m_wait = 0;
        else if (m_wait < LIMIT) m_wait++;
        if (stl) m_vld = 1'b0;
        else begin
            m_vld = mem_valid_i; m_we = mem_reg_write_i; m_rd = mem_rd_addr_i;
            m_data = (mem_to_reg_i == 2'b01) ? mem_rdata_i :
                     (mem_to_reg_i == 2'b10) ? mem_pc_plus_4_i : mem_alu_result_i;
        end
    endtask

    initial begin
        logic        pend_v;
        logic [4:0]  pend_rd;
        logic [31:0] pend_d;

        tbl[0] = '{1'b1, 1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234, 0};
        tbl[1] = '{1'b1, 1'b1, 5'd6, 2'b01, 32'h5, 32'hDEADBEEF, 32'h4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hDEADBEEF, 0};
        tbl[2] = '{1'b1, 1'b1, 5'd1, 2'b10, 32'h6, 32'h7, 32'h108, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h108, 0};
        tbl[3] = '{1'b1, 1'b1, 5'd0, 2'b00, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 0};
        tbl[4] = '{1'b1, 1'b1, 5'd3, 2'b11, 32'h77, 32'h88, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h77, 0};
        tbl[5] = '{1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 32'h99, 1};
        tbl[6] = '{1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 0};
        tbl[7] = '{1'b1, 1'b0, 5'd9, 2'b00, 32'h3, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 0};

        rst_n = 1'b0;
        set_mem(0, 0, 0, 0, 0, 0, 0);
        set_div(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        exp6("reset", 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_mem(tbl[i].mv, tbl[i].rw, tbl[i].rd, tbl[i].mt, tbl[i].alu, tbl[i].rdata, tbl[i].pc4);
            set_div(tbl[i].dv, tbl[i].drd, tbl[i].dd);
            step();
            exp6($sformatf("vec%0d", i), tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_data,
                 tbl[i].e_cnt, tbl[i].e_cnt < DEPTH, 1'b0);
        end

        // Fill the FIFO behind continuous pipeline writes and let the head starve.
        set_mem(1, 1, 10, 0, 32'h100, 0, 0); set_div(1, 1, 32'hA); step();
        exp6("st1", 1, 10, 32'h100, 1, 1, 0);
        set_mem(1, 1, 10, 0, 32'h101, 0, 0); set_div(1, 2, 32'hB); step();
        exp6("st2", 1, 10, 32'h101, 2, 0, 0);
        set_mem(1, 1, 10, 0, 32'h102, 0, 0); set_div(1, 3, 32'hC); step();
        exp6("st3", 1, 10, 32'h102, 2, 0, 0);
        set_mem(1, 1, 10, 0, 32'h103, 0, 0); step();
        exp6("st4", 1, 10, 32'h103, 2, 0, 0);
        set_mem(1, 1, 10, 0, 32'h104, 0, 0); step();
        exp6("st5", 1, 10, 32'h104, 2, 0, 1);
        set_mem(1, 1, 11, 0, 32'h200, 0, 0); step();
        exp6("st6", 1, 1, 32'hA, 2, 0, 0);
        step();
        exp6("st7", 1, 11, 32'h200, 1, 1, 0);
        set_mem(0, 0, 0, 0, 0, 0, 0); step();
        exp6("st8", 1, 2, 32'hB, 2, 0, 0);
        set_div(0, 0, 0); step();
        exp6("st9", 1, 3, 32'hC, 1, 1, 0);
        step();
        exp6("st10", 0, 0, 0, 0, 1, 0);

        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        pend_v = 1'b0; pend_rd = 5'd0; pend_d = 32'd0;
        for (int i = 0; i < 400; i++) begin
            model_check();
            if (m_wait != LIMIT) begin
                set_mem(($urandom % 10) < ((i < 200) ? 9 : 4), ($urandom % 5) != 0,
                        5'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom, $urandom);
            end
            if (!pend_v && ($urandom % 3) == 0) begin
                pend_v = 1'b1; pend_rd = 5'($urandom_range(0, 7)); pend_d = $urandom;
            end
            set_div(pend_v, pend_rd, pend_d);
            if (pend_v && mq.size() < DEPTH) pend_v = 1'b0;
            model_advance();
            step();
        end

        // Asynchronous reset in the middle of traffic, with the FIFO forced non-empty.
        set_mem(1, 1, 12, 0, 32'h300, 0, 0); set_div(1, 4, 32'h44); step();
        set_div(1, 5, 32'h55); step();
        #1 rst_n = 1'b0;
        #1 exp6("midrst", 0, 0, 0, 0, 1, 0);
        set_mem(0, 0, 0, 0, 0, 0, 0); set_div(0, 0, 0);
        #1 rst_n = 1'b1;
        #1 exp6("rel", 0, 0, 0, 0, 1, 0);
        step();
        exp6("post", 0, 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
